// File: rtl/line_tx_scheduler.sv
// line_tx_scheduler
// Streams one frame-buffer line per packet as RMII-style dibits: an 8-dibit
// header (three zero dibits, then the 10-bit line number MSB first) followed
// by LINE_PIXELS RGB565 pixels, 8 dibits each, MSB first. Each packet is
// followed by IPG_CYCLES idle cycles. Lines advance per packet and wrap at
// NUM_LINES; a frame_start pulse restarts at line 0.
//
// Ports
//   clk_in            single clock for all logic
//   rst_in            synchronous, active-high reset
//   enable_in         permits a new packet to start
//   ready_in          transmitter can accept a packet
//   frame_start_in    one-cycle pulse: restart at line 0
//   pixel_data_in     frame-buffer read data, valid 2 cycles after the address
//   pixel_addr_out    frame-buffer read address
//   axiov_out         dibit valid
//   axiod_out         dibit data (00 whenever axiov_out is low)
//   line_out          line number of the current or next packet
//   packet_count_out  completed packets, wraps at 16 bits
//   busy_out          high whenever not idle
module line_tx_scheduler #(
   parameter int LINE_PIXELS = 240,
   parameter int NUM_LINES   = 320,
   parameter int IPG_CYCLES  = 36
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        enable_in,
   input  logic        ready_in,
   input  logic        frame_start_in,
   input  logic [15:0] pixel_data_in,
   output logic [16:0] pixel_addr_out,
   output logic        axiov_out,
   output logic [1:0]  axiod_out,
   output logic [9:0]  line_out,
   output logic [15:0] packet_count_out,
   output logic        busy_out
);

   localparam int PW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
   localparam int IW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, HEADER, DATA, IPG} state_t;

   state_t          state, state_nx;
   logic [2:0]      dibit_cnt;
   logic [PW-1:0]   pix_cnt;
   logic [IW-1:0]   ipg_cnt;
   logic [15:0]     shreg;
   logic [16:0]     base_addr;
   logic [16:0]     addr;
   logic [9:0]      line;
   logic [15:0]     pkt_cnt;
   logic            restart_pend;

   logic start, last_dibit, last_pix, ipg_done, line_wrap;

   assign start      = enable_in & ready_in;
   assign last_dibit = (dibit_cnt == 3'd7);
   assign last_pix   = (pix_cnt == PW'(LINE_PIXELS - 1));
   assign ipg_done   = (ipg_cnt == IW'(IPG_CYCLES - 1));
   assign line_wrap  = (line == 10'(NUM_LINES - 1));

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = HEADER;
         HEADER:  if (last_dibit) state_nx = DATA;
         DATA:    if (last_dibit && last_pix) state_nx = IPG;
         IPG:     if (ipg_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         dibit_cnt    <= '0;
         pix_cnt      <= '0;
         ipg_cnt      <= '0;
         shreg        <= '0;
         base_addr    <= '0;
         addr         <= '0;
         line         <= '0;
         pkt_cnt      <= '0;
         restart_pend <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start_in) begin
                  line      <= '0;
                  base_addr <= '0;
               end
               // A coincident frame_start wins, so the packet carries line 0
               // and fetches from address 0.
               if (start) begin
                  shreg     <= {6'b0, frame_start_in ? 10'd0 : line};
                  addr      <= frame_start_in ? 17'd0 : base_addr;
                  dibit_cnt <= '0;
               end
            end
            HEADER: begin
               if (frame_start_in) restart_pend <= 1'b1;
               dibit_cnt <= dibit_cnt + 3'd1;
               // Pixel 0's address has been up since the header began, so the
               // read data is valid by the last header dibit.
               if (last_dibit) begin
                  shreg   <= pixel_data_in;
                  addr    <= addr + 17'd1;
                  pix_cnt <= '0;
               end else begin
                  shreg <= shreg << 2;
               end
            end
            DATA: begin
               if (frame_start_in) restart_pend <= 1'b1;
               dibit_cnt <= dibit_cnt + 3'd1;
               if (last_dibit) begin
                  if (last_pix) begin
                     ipg_cnt   <= '0;
                     pkt_cnt   <= pkt_cnt + 16'd1;
                     line      <= line_wrap ? 10'd0 : line + 10'd1;
                     base_addr <= line_wrap ? 17'd0 : base_addr + 17'(LINE_PIXELS);
                  end else begin
                     // Next address is presented a full pixel time ahead of use.
                     shreg   <= pixel_data_in;
                     addr    <= addr + 17'd1;
                     pix_cnt <= pix_cnt + PW'(1);
                  end
               end else begin
                  shreg <= shreg << 2;
               end
            end
            IPG: begin
               ipg_cnt <= ipg_cnt + IW'(1);
               if (frame_start_in) restart_pend <= 1'b1;
               // Deferred restart overrides the advance made at IPG entry.
               if (ipg_done) begin
                  if (restart_pend || frame_start_in) begin
                     line      <= '0;
                     base_addr <= '0;
                  end
                  restart_pend <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign axiov_out        = (state == HEADER) || (state == DATA);
   assign axiod_out        = axiov_out ? shreg[15:14] : 2'b00;
   assign busy_out         = (state != IDLE);
   assign pixel_addr_out   = addr;
   assign line_out         = line;
   assign packet_count_out = pkt_cnt;

endmodule
